uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_arb.sv | 29 ++
 rtl/uart_tx_sched.sv | 121 ++++++++++++
 tb/tb_uart_tx_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// the default watchdog limit.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b10
    } state_t;

    localparam logic [15:0] TIMEOUT_CYC_DEFAULT = 16'd4000;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: returns the first active request found
// when scanning upward from the priority pointer, wrapping at NUM_REQ.
module uart_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_any_req
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    int unsigned w_idx;

    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(i_rr_ptr) + i) % NUM_REQ;
            if (!o_any_req && i_req[w_idx]) begin
                o_grant   = PW'(w_idx);
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin grants.
// Optional WAIT_DONE watchdog is built only with UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                       clk2,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_grant_id;
    logic [7:0]      r_tx_data;
    logic [PW-1:0]   w_arb_grant;
    logic            w_any_req;
    logic [7:0]      w_sel_byte;
    logic [PW-1:0]   w_ptr_wrap;
    logic            w_frame_end;
    logic            w_wdog_hit;
    logic            w_timeout_err;

    uart_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req     (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant   (w_arb_grant),
        .o_any_req (w_any_req)
    );

    assign w_sel_byte  = req_data[8*w_arb_grant +: 8];
    assign w_ptr_wrap  = (r_grant_id == PW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_frame_end = (r_state == WAIT_DONE) && (tx_done || w_wdog_hit);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        r_timeout_err;

    // r_wdog holds the number of WAIT_DONE cycles already completed, so the
    // limit is reached on the TIMEOUT_CYC-th cycle spent waiting.
    assign w_wdog_hit    = (r_state == WAIT_DONE) && ((r_wdog + 16'd1) == TIMEOUT_CYC);
    assign w_timeout_err = r_timeout_err;

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == WAIT_DONE) begin
                r_wdog <= r_wdog + 16'd1;
            end else begin
                r_wdog <= '0;
            end
            if (w_wdog_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_hit    = 1'b0;
    assign w_timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_any_req)   w_state_next = ISSUE;
            ISSUE:                      w_state_next = WAIT_DONE;
            WAIT_DONE: if (w_frame_end) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any_req) begin
                r_grant_id <= w_arb_grant;
                r_tx_data  <= w_sel_byte;
            end
            if (w_frame_end) begin
                r_rr_ptr <= w_ptr_wrap;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        if (r_state == ISSUE) begin
            req_ready[r_grant_id] = 1'b1;
            tx_start              = 1'b1;
        end
    end

    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != IDLE);
    assign timeout_err = w_timeout_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (NUM_REQ=4, TIMEOUT_CYC=20).
// Inputs change and outputs are sampled on the falling edge of clk2.
module tb_uart_tx_sched;

    logic        clk2 = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_sched #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .clk2        (clk2),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk2 = ~clk2;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk2);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; tx_done = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        // a tx_done in IDLE must not move the pointer or the state
        pulse_done();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_done_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        tick();
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_tx_start got %b want 1", tx_start); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data got %h want a5", tx_data); end
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant got %0d want 2", grant_id); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_pulse got %b want 0", tx_start); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_wait got %b want 1", busy); end
        tick(3);
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold got %h want a5", tx_data); end
        pulse_done();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_idle got %b want 0", busy); end
    endtask

    // pointer is 3 after serving port 2, so ports 0/1 pending must yield port 0
    task automatic test_wrap();
        req_data  = 32'h0000_5A3C;
        req_valid = 4'b0011;
        tick();
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL wrap_grant got %0d want 0", grant_id); end
        n_checks++; if (tx_data !== 8'h3C) begin n_fail++; $display("FAIL wrap_tx_data got %h want 3c", tx_data); end
        tick();
        req_valid = '0;
        pulse_done();
    endtask

    task automatic test_fairness();
        logic [7:0] exp_byte;
        bit         seen;
        do_reset();
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 6 && !seen; c++) begin
                tick();
                seen = (tx_start === 1'b1);
            end
            n_checks++; if (!seen) begin n_fail++; $display("FAIL fair_start_timeout grant %0d got no tx_start want tx_start", k); end
            exp_byte = 8'h11 * 8'(k % 4 + 1);
            n_checks++; if (grant_id !== 2'(k % 4)) begin n_fail++; $display("FAIL fair_grant_%0d got %0d want %0d", k, grant_id, k % 4); end
            n_checks++; if (tx_data !== exp_byte) begin n_fail++; $display("FAIL fair_data_%0d got %h want %h", k, tx_data, exp_byte); end
            tick(9);
            pulse_done();
        end
        req_valid = '0;
        tick(2);
    endtask

    task automatic test_coincide();
        do_reset();
        req_data  = 32'h0000_B2C1;
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid = '0;
        tick();
        // pending requests are not looked at while a frame is in flight
        req_valid = 4'b0010;
        tick(3);
        n_checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_ignores_req got start=%b busy=%b want start=0 busy=1", tx_start, busy); end
        pulse_done();
        n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL coincide_idle got busy=%b start=%b want busy=0 start=0", busy, tx_start); end
        tick();
        n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL coincide_start got %b want 1", tx_start); end
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL coincide_grant got %0d want 1", grant_id); end
        tick();
        req_valid = '0;
        pulse_done();
    endtask

    task automatic test_reset_mid();
        int bad_ready;
        req_data  = 32'h7700_0000;
        req_valid = 4'b1000;
        tick(2);
        req_valid = '0;
        tick(2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (grant_id !== 2'd0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_regs got grant=%0d data=%h want grant=0 data=00", grant_id, tx_data); end
        bad_ready = 0;
        tx_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            tx_done = 1'b0;
            if (req_ready !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0) bad_ready++;
        end
        n_checks++; if (bad_ready !== 0) begin n_fail++; $display("FAIL midrst_stray_done got %0d bad cycles want 0", bad_ready); end
        // pointer must be back at 0 after reset, not advanced by the stray tx_done
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        tick();
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_ptr got %0d want 0", grant_id); end
        tick();
        req_valid = '0;
        pulse_done();
    endtask

    task automatic test_watchdog();
        do_reset();
        req_data  = 32'h0000_EE00;
        req_valid = 4'b0010;
        tick();
        tick();
        req_valid = '0;
        tick(19);
        n_checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL wdog_cycle20 got busy=%b err=%b want busy=1 err=0", busy, timeout_err); end
        tick();
`ifdef UART_TX_SCHED_TIMEOUT_EN
        n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL wdog_expire got busy=%b err=%b want busy=0 err=1", busy, timeout_err); end
        tick(5);
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky got %b want 1", timeout_err); end
        req_valid = 4'b1111;
        tick();
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL wdog_ptr got %0d want 2", grant_id); end
        req_valid = '0;
        tick();
        pulse_done();
`else
        tick(10);
        n_checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL wdog_off got busy=%b err=%b want busy=1 err=0", busy, timeout_err); end
        pulse_done();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wdog_off_done got %b want 0", busy); end
`endif
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; tx_done = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_coincide();
        test_reset_mid();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no end of test want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
